// File: rtl/conv_sched_pkg.sv
// Shared types for the conv layer job scheduler (optional watchdog: CONV_SCHED_TIMEOUT_EN).
package conv_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    RUN,
    DONE
  } sched_state_t;

  // The pixel counter must be able to hold the full pixel count, not just count-1.
  function automatic int pix_cnt_width(input int pixels);
    return $clog2(pixels + 1);
  endfunction

endpackage

// File: rtl/conv_sched_watchdog.sv
// Idle-cycle watchdog for the scheduler RUN state; only built with CONV_SCHED_TIMEOUT_EN.
module conv_sched_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Expiry is flagged in the cycle before the limit so the abort edge lands exactly TIMEOUT_CYCLES after the last clear.
  assign expire_o = en_i && !clr_i && (cnt_q == LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/conv_layer_sched.sv
// Job-level scheduler for one conv engine: weight load, engine start, result counting, bank flip.
// Optional RUN watchdog with error token is enabled by defining CONV_SCHED_TIMEOUT_EN.
module conv_layer_sched
  import conv_sched_pkg::*;
#(
  parameter int RESULT_W       = 6,
  parameter int RESULT_H       = 6,
  parameter int GROUP_WIDTH    = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   job_val,
  output logic                   job_rdy,
  input  logic [GROUP_WIDTH-1:0] job_num_groups,
  output logic                   wgt_load_req,
  output logic [GROUP_WIDTH-1:0] wgt_group_sel,
  input  logic                   wgt_load_ack,
  output logic                   eng_val_in,
  input  logic                   eng_rdy_in,
  input  logic                   eng_result_wren,
  output logic                   bank_sel,
  output logic                   done_val,
  input  logic                   done_rdy,
  output logic                   done_err
);

  localparam int RESULT_PIXELS = RESULT_W * RESULT_H;
  localparam int PIX_W         = pix_cnt_width(RESULT_PIXELS);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(RESULT_PIXELS - 1);

  sched_state_t           state_q;
  logic                   job_rdy_q;
  logic                   wgt_req_q;
  logic                   eng_val_q;
  logic                   done_val_q;
  logic                   bank_q;
  logic [GROUP_WIDTH-1:0] group_q;
  logic [GROUP_WIDTH-1:0] num_groups_q;
  logic [PIX_W-1:0]       pix_cnt_q;

  assign job_rdy       = job_rdy_q;
  assign wgt_load_req  = wgt_req_q;
  assign wgt_group_sel = group_q;
  assign eng_val_in    = eng_val_q;
  assign bank_sel      = bank_q;
  assign done_val      = done_val_q;

`ifdef CONV_SCHED_TIMEOUT_EN
  logic wd_expire;
  logic done_err_q;

  conv_sched_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .clr_i    ((state_q != RUN) || eng_result_wren),
    .en_i     (state_q == RUN),
    .expire_o (wd_expire)
  );

  // Error flag is set on the abort edge and held with done_val until the token is taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_err_q <= 1'b0;
    end else if (state_q == RUN && wd_expire) begin
      done_err_q <= 1'b1;
    end else if (state_q == DONE && done_rdy) begin
      done_err_q <= 1'b0;
    end
  end

  assign done_err = done_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign done_err       = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      job_rdy_q    <= 1'b0;
      wgt_req_q    <= 1'b0;
      eng_val_q    <= 1'b0;
      done_val_q   <= 1'b0;
      bank_q       <= 1'b0;
      group_q      <= '0;
      num_groups_q <= '0;
      pix_cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          job_rdy_q <= 1'b1;
          if (job_val && job_rdy_q) begin
            job_rdy_q    <= 1'b0;
            num_groups_q <= job_num_groups;
            group_q      <= '0;
            if (job_num_groups == '0) begin
              done_val_q <= 1'b1;
              state_q    <= DONE;
            end else begin
              wgt_req_q <= 1'b1;
              state_q   <= LOAD;
            end
          end
        end
        LOAD: begin
          if (wgt_load_ack) begin
            wgt_req_q <= 1'b0;
            eng_val_q <= 1'b1;
            state_q   <= START;
          end
        end
        START: begin
          if (eng_rdy_in) begin
            eng_val_q <= 1'b0;
            pix_cnt_q <= '0;
            state_q   <= RUN;
          end
        end
        RUN: begin
          if (eng_result_wren) begin
            pix_cnt_q <= pix_cnt_q + 1'b1;
            // Comparing against num_groups-1 keeps the group index inside 0..num_groups-1.
            if (pix_cnt_q == PIX_LAST) begin
              bank_q <= ~bank_q;
              if (group_q != num_groups_q - 1'b1) begin
                group_q   <= group_q + 1'b1;
                wgt_req_q <= 1'b1;
                state_q   <= LOAD;
              end else begin
                done_val_q <= 1'b1;
                state_q    <= DONE;
              end
            end
          end
`ifdef CONV_SCHED_TIMEOUT_EN
          else if (wd_expire) begin
            done_val_q <= 1'b1;
            state_q    <= DONE;
          end
`endif
        end
        DONE: begin
          if (done_rdy) begin
            done_val_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
